keypad_scan: RTL

- 4x4 matrix keypad scanner and debouncer that feeds the stopwatch/calculator top level. It supplies the 4-bit `keyword` and 2-bit `flag_pressed` that drive the mode, stopwatch and calculator logic.
- Drives the row lines one at a time and samples the column lines. Produces one debounced key code per physical press, plus press, hold and release status.
- Sits directly upstream of the operand reader and the mode logic.

---
 rtl/keypad_scan.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner and debouncer.
//
// Drives one active-low row line at a time and samples the active-low column
// lines once per row dwell period (the "sample tick"). The first low column
// it finds locks the scanner onto that row. The key is accepted after
// DEBOUNCE_N consecutive low samples, which emits a one-cycle press pulse.
// It is reported as held until DEBOUNCE_N consecutive high samples have been
// seen, and then a one-cycle release pulse is emitted. While the scanner is
// locked, keys in other rows are invisible because their rows are not driven.
//
// flag_pressed encoding: 00 idle, 01 press pulse, 10 held, 11 release pulse.
// keyword keeps the code of the last accepted key until the next press or
// a reset.
module keypad_scan #(
  parameter int SCAN_DIV   = 50000,  // clk cycles per row dwell, >= 4
  parameter int DEBOUNCE_N = 8       // identical samples to accept, 2..255
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] LINE,
  input  logic [3:0] COLLUMMN,
  output logic [3:0] keyword,
  output logic [1:0] flag_pressed
);

  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [7:0]       DEB_LAST = 8'(DEBOUNCE_N);

  typedef enum logic [1:0] {
    SCAN,       // rotating through the rows, looking for a low column
    DEB_PRESS,  // row locked, counting consecutive low samples
    HELD,       // key accepted, waiting for the column to go high
    DEB_REL     // counting consecutive high samples
  } state_t;

  typedef enum logic [1:0] {
    FLAG_IDLE    = 2'b00,
    FLAG_PRESS   = 2'b01,
    FLAG_HELD    = 2'b10,
    FLAG_RELEASE = 2'b11
  } flag_t;

  // Candidate key: the row that was driven and the column that was seen low.
  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } cand_t;

  // Synchronised column inputs.
  logic [3:0]       col_meta;
  logic [3:0]       col_s;

  // Row dwell timer.
  logic [DIV_W-1:0] div_cnt;
  logic             sample_tick;

  // Scanner and debounce state.
  state_t           state_q, state_d;
  logic [1:0]       row_q, row_d;
  cand_t            cand_q, cand_d;
  logic [7:0]       deb_cnt_q, deb_cnt_d;
  logic [3:0]       keyword_q, keyword_d;
  flag_t            flag_q, flag_d;

  // Decoded views of the sampled columns.
  logic             hit_any;
  logic [1:0]       hit_col;
  logic             cand_low;
  logic [7:0]       deb_inc;
  logic             deb_done;

  // Maps a (row, column) position to the code printed on the keypad.
  function automatic logic [3:0] key_code(input cand_t k);
    logic [3:0] code;
    code = 4'd0;
    case ({k.row, k.col})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = 4'd10;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = 4'd11;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = 4'd12;
      4'hC: code = 4'd14;
      4'hD: code = 4'd0;
      4'hE: code = 4'd15;
      4'hF: code = 4'd13;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  // Two-flop synchroniser for the asynchronous column inputs.
  // NOTE: non-blocking assignments make every flop load the value it saw
  // before the edge, which is what makes this a two-stage pipeline at all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta <= 4'b1111;
      col_s    <= 4'b1111;
    end else begin
      col_meta <= COLLUMMN;
      col_s    <= col_meta;
    end
  end

  // Row dwell timer. It wraps every SCAN_DIV cycles and its last count is
  // the sample tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (sample_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign sample_tick = (div_cnt == DIV_LAST);

  // Column decode. The lowest low column wins when several are low.
  always_comb begin
    hit_any = (col_s != 4'b1111);
    if (!col_s[0]) begin
      hit_col = 2'd0;
    end else if (!col_s[1]) begin
      hit_col = 2'd1;
    end else if (!col_s[2]) begin
      hit_col = 2'd2;
    end else begin
      hit_col = 2'd3;
    end
  end

  assign cand_low = ~col_s[cand_q.col];
  assign deb_inc  = deb_cnt_q + 8'd1;
  assign deb_done = (deb_inc == DEB_LAST);

  // Next-state, debounce counting and status flag. Nothing moves except on
  // a sample tick, apart from the flag, which drops back after one cycle.
  // NOTE: every signal gets its default first, so no path leaves a value
  // unassigned and no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    cand_d    = cand_q;
    deb_cnt_d = deb_cnt_q;
    keyword_d = keyword_q;
    flag_d    = FLAG_IDLE;

    if (sample_tick) begin
      case (state_q)
        SCAN: begin
          if (!hit_any) begin
            row_d = row_q + 2'd1;
          end else begin
            cand_d    = '{row: row_q, col: hit_col};
            deb_cnt_d = 8'd1;
            state_d   = DEB_PRESS;
          end
        end
        DEB_PRESS: begin
          if (!cand_low) begin
            // Bounce or glitch: drop the candidate and resume scanning
            // from the same row.
            deb_cnt_d = 8'd0;
            state_d   = SCAN;
          end else if (deb_done) begin
            keyword_d = key_code(cand_q);
            deb_cnt_d = 8'd0;
            state_d   = HELD;
            flag_d    = FLAG_PRESS;
          end else begin
            deb_cnt_d = deb_inc;
          end
        end
        HELD: begin
          if (!cand_low) begin
            deb_cnt_d = 8'd1;
            state_d   = DEB_REL;
          end
        end
        DEB_REL: begin
          if (cand_low) begin
            // The contact closed again before the release was accepted.
            deb_cnt_d = 8'd0;
            state_d   = HELD;
          end else if (deb_done) begin
            deb_cnt_d = 8'd0;
            row_d     = row_q + 2'd1;
            state_d   = SCAN;
            flag_d    = FLAG_RELEASE;
          end else begin
            deb_cnt_d = deb_inc;
          end
        end
        default: begin
          state_d = SCAN;
        end
      endcase
    end

    // Outside the pulse cycles, the flag reports held for as long as a key
    // is accepted.
    if (flag_d == FLAG_IDLE && (state_d == HELD || state_d == DEB_REL)) begin
      flag_d = FLAG_HELD;
    end
  end

  // Scanner state, candidate key, debounce count and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SCAN;
      row_q     <= 2'd0;
      cand_q    <= '0;
      deb_cnt_q <= 8'd0;
      keyword_q <= 4'd0;
      flag_q    <= FLAG_IDLE;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      cand_q    <= cand_d;
      deb_cnt_q <= deb_cnt_d;
      keyword_q <= keyword_d;
      flag_q    <= flag_d;
    end
  end

  // Active-low row drive. Exactly one line is low, chosen by the row register.
  always_comb begin
    LINE = 4'b1110;
    case (row_q)
      2'd0: LINE = 4'b1110;
      2'd1: LINE = 4'b1101;
      2'd2: LINE = 4'b1011;
      2'd3: LINE = 4'b0111;
      default: LINE = 4'b1110;
    endcase
  end

  assign keyword      = keyword_q;
  assign flag_pressed = flag_q;

endmodule
